tap_delay_line: RTL and testbench
=================================

Name: tap_delay_line

Overview:
Parametrised tapped delay line: a chain of DEPTH registers, each WIDTH bits wide, with a selectable output tap. It generalises the fixed 3-stage, 8-bit tap-select shifter. It adds a shift enable, a synchronous flush, per-stage valid tracking and an occupancy counter. It sits in datapaths that need a run-time programmable 0..DEPTH cycle delay.

Parameters:
WIDTH, 8, data width in bits (>= 1)
DEPTH, 3, number of register stages (>= 1); maximum delay in enabled cycles
SEL_W, 2, tap-select width; integration must guarantee 2**SEL_W >= DEPTH+1
CNT_W, 2, occupancy counter width; integration must guarantee 2**CNT_W >= DEPTH+1

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  asynchronous, active-low reset
en  input  1  shift enable; chain advances one stage on a clock edge when 1
flush  input  1  synchronous clear of all stages, valids and count
d  input  WIDTH  input data
d_valid  input  1  qualifies d
sel  input  SEL_W  tap select: 0 = bypass, k = output of stage k (1..DEPTH)
q  output  WIDTH  selected tap data (combinational from sel and state)
q_valid  output  1  valid bit of the selected tap
fill  output  CNT_W  registered count of valid stages, 0..DEPTH
full  output  1  fill == DEPTH

Behaviour:
- State: stage[1..DEPTH] (WIDTH bits each), vld[1..DEPTH], fill counter.
- Reset (reset=0, asynchronous, independent of clk):
  - all stage = 0, all vld = 0, fill = 0.
  - Consequently q = 0 and q_valid = 0 for any sel>=1, and full = 0.
  - Release is synchronous to clk; the first edge with reset=1 behaves normally.
- Priority at each rising edge: flush > en > hold.
- flush=1: stage, vld and fill cleared to 0 on that edge, regardless of en and d_valid. The current d is discarded.
- en=1, flush=0:
  - stage[1] <= d; vld[1] <= d_valid.
  - stage[k] <= stage[k-1] and vld[k] <= vld[k-1], for k = 2..DEPTH.
  - stage[DEPTH] contents are dropped.
- en=0, flush=0: all state held.
- Data is captured regardless of d_valid. The validity of each stage is carried only by vld.
- Output mux (purely combinational, zero latency from sel):
  - sel=0: q = d, q_valid = d_valid.
  - sel=k with 1<=k<=DEPTH: q = stage[k], q_valid = vld[k].
  - sel>DEPTH: q = 0, q_valid = 0.
- Delay: with en held at 1, data presented at edge n appears at tap k after edge n+k-1. It is visible in the cycle following k enabled edges.
- fill update on an enabled edge: fill_next = fill + d_valid - vld[DEPTH].
  - Simultaneous entry and exit leaves fill unchanged.
  - fill never exceeds DEPTH and never underflows.
  - fill must equal the popcount of vld after every edge.
- full is decoded from the registered fill (no comb path from inputs).
- sel may change on any cycle. It has no effect on state.
- Reset asserted mid-stream aborts all in-flight data immediately. No partial shift occurs on that edge.
- DEPTH=1 degenerate case must work: sel=1 selects the only stage, full = vld[1].

Test Plan:
- Reset/flush: drive reset=0 mid-stream with stages holding 0xA5 -> q=0 (sel=1..3), q_valid=0 and fill=0 immediately, without waiting for a clock edge. Then after refill, flush=1 with en=1, d=0x11 -> all stages 0, fill=0 next cycle, 0x11 not captured.
- Tap delay (WIDTH=8, DEPTH=3): en=1, d_valid=1, d=0x01,0x02,0x03,0x04 on successive edges.
  - After edge 4 with sel=1/2/3 -> q=0x04/0x03/0x02, q_valid=1.
  - sel=0 -> q = current d, combinationally.
- Enable stall: fill with 0x10,0x20,0x30, then en=0 for 5 cycles with d=0xFF -> stage contents, fill=3 and full=1 unchanged. The next en=1, d=0x40 -> sel=3 gives 0x20.
- Occupancy: DEPTH=3, en=1, d_valid pattern 1,0,1,1,0,0,0.
  - fill after each edge -> 1,1,2,2,2,1,0 (increment on entry, decrement on exit of a valid stage[3]).
  - full asserted for no cycle.
  - With pattern 1,1,1,1: fill -> 1,2,3,3 and full=1 from edge 3.
- Out-of-range select: DEPTH=5, SEL_W=3, CNT_W=3, sel=6 and 7 with valid data present -> q=0, q_valid=0. sel=5 -> oldest stage data, delay of 5 enabled edges.
- Randomised stream with random en/flush/d_valid/sel compared against a reference queue model -> q, q_valid and fill match every cycle. Include DEPTH=1 and WIDTH=1 configurations.

Source files
------------

// File: rtl/tap_delay_line_if.sv
`default_nettype none
// ============================================================================
// Module      : tap_delay_line_if
// Description : Data/control bundle for the tapped delay line.
// Revision    : 1.0
// ============================================================================
interface tap_delay_line_if #(
    parameter int WIDTH = 8,
    parameter int SEL_W = 2,
    parameter int CNT_W = 2
);
    logic             en;
    logic             flush;
    logic [WIDTH-1:0] d;
    logic             d_valid;
    logic [SEL_W-1:0] sel;
    logic [WIDTH-1:0] q;
    logic             q_valid;
    logic [CNT_W-1:0] fill;
    logic             full;

    modport master (
        output en, flush, d, d_valid, sel,
        input  q, q_valid, fill, full
    );

    modport slave (
        input  en, flush, d, d_valid, sel,
        output q, q_valid, fill, full
    );
endinterface
`default_nettype wire

// File: rtl/tap_delay_line.sv
`default_nettype none
// ============================================================================
// Module      : tap_delay_line
// Description : DEPTH-stage delay line with per-stage valids, occupancy count
//               and a combinational run-time tap select (0 = bypass).
// Revision    : 1.0
// ============================================================================
module tap_delay_line #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 3,
    parameter int SEL_W = 2,
    parameter int CNT_W = 2
) (
    input  wire logic       clk,
    input  wire logic       reset,
    tap_delay_line_if.slave bus
);

    logic [WIDTH-1:0] r_stage [1:DEPTH];
    logic [DEPTH:1]   r_vld;
    logic [CNT_W-1:0] r_fill;
    logic [CNT_W-1:0] w_fill_next;
    logic [WIDTH-1:0] w_q;
    logic             w_qv;

    // Entry and exit of a valid word on the same edge cancel out.
    assign w_fill_next = r_fill + CNT_W'(bus.d_valid) - CNT_W'(r_vld[DEPTH]);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 1; k <= DEPTH; k++) r_stage[k] <= '0;
            r_vld  <= '0;
            r_fill <= '0;
        end else if (bus.flush) begin
            for (int k = 1; k <= DEPTH; k++) r_stage[k] <= '0;
            r_vld  <= '0;
            r_fill <= '0;
        end else if (bus.en) begin
            r_stage[1] <= bus.d;
            r_vld[1]   <= bus.d_valid;
            for (int k = 2; k <= DEPTH; k++) begin
                r_stage[k] <= r_stage[k-1];
                r_vld[k]   <= r_vld[k-1];
            end
            r_fill <= w_fill_next;
        end
    end

    always_comb begin
        w_q  = '0;
        w_qv = 1'b0;
        if (bus.sel == '0) begin
            w_q  = bus.d;
            w_qv = bus.d_valid;
        end else begin
            for (int k = 1; k <= DEPTH; k++) begin
                if (int'(bus.sel) == k) begin
                    w_q  = r_stage[k];
                    w_qv = r_vld[k];
                end
            end
        end
    end

    assign bus.q       = w_q;
    assign bus.q_valid = w_qv;
    assign bus.fill    = r_fill;
    assign bus.full    = (r_fill == CNT_W'(DEPTH));

endmodule
`default_nettype wire

// File: tb/tb_tap_delay_line.sv
`default_nettype none
// ============================================================================
// Module      : tb_tap_delay_line
// Description : Self-checking bench; three configurations share one stimulus.
// Revision    : 1.0
// ============================================================================
module tb_tap_delay_line;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       en, flush, dv;
    logic [7:0] d;
    logic [1:0] sel_a;
    logic [2:0] sel_b;
    logic       sel_c;

    int n_err = 0;
    int n_chk = 0;

    tap_delay_line_if #(.WIDTH(8), .SEL_W(2), .CNT_W(2)) ifa ();
    tap_delay_line_if #(.WIDTH(8), .SEL_W(3), .CNT_W(3)) ifb ();
    tap_delay_line_if #(.WIDTH(1), .SEL_W(1), .CNT_W(1)) ifc ();

    assign ifa.en = en;  assign ifa.flush = flush; assign ifa.d = d;    assign ifa.d_valid = dv; assign ifa.sel = sel_a;
    assign ifb.en = en;  assign ifb.flush = flush; assign ifb.d = d;    assign ifb.d_valid = dv; assign ifb.sel = sel_b;
    assign ifc.en = en;  assign ifc.flush = flush; assign ifc.d = d[0]; assign ifc.d_valid = dv; assign ifc.sel = sel_c;

    tap_delay_line #(.WIDTH(8), .DEPTH(3), .SEL_W(2), .CNT_W(2)) u_a (.clk(clk), .reset(reset), .bus(ifa));
    tap_delay_line #(.WIDTH(8), .DEPTH(5), .SEL_W(3), .CNT_W(3)) u_b (.clk(clk), .reset(reset), .bus(ifb));
    tap_delay_line #(.WIDTH(1), .DEPTH(1), .SEL_W(1), .CNT_W(1)) u_c (.clk(clk), .reset(reset), .bus(ifc));

    // Reference model: plain shift arrays, occupancy recomputed as a popcount.
    int         dep [3] = '{3, 5, 1};
    logic [7:0] wm  [3] = '{8'hFF, 8'hFF, 8'h01};
    logic [7:0] m_st [3][6];
    logic       m_vl [3][6];
    int         m_fill [3];

    typedef struct {
        int         inst;
        logic [7:0] q;
        logic       qv;
        int         fill;
        logic       full;
    } exp_t;
    exp_t sbq [$];

    typedef struct {
        logic [7:0]  d;
        logic        dv;
        logic        has_q;
        logic [23:0] q;
        logic [2:0]  v;
        int          fill;
        logic        full;
    } vec_t;
    vec_t tv [15];

    task automatic chk(string nm, int act, int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 3; i++) begin
            for (int k = 0; k < 6; k++) begin
                m_st[i][k] = '0;
                m_vl[i][k] = 1'b0;
            end
            m_fill[i] = 0;
        end
    endtask

    task automatic model_edge();
        if (!reset || flush) begin
            model_clear();
        end else if (en) begin
            for (int i = 0; i < 3; i++) begin
                for (int k = dep[i]; k >= 2; k--) begin
                    m_st[i][k] = m_st[i][k-1];
                    m_vl[i][k] = m_vl[i][k-1];
                end
                m_st[i][1] = d & wm[i];
                m_vl[i][1] = dv;
                m_fill[i]  = 0;
                for (int k = 1; k <= dep[i]; k++) m_fill[i] += int'(m_vl[i][k]);
            end
        end
    endtask

    function automatic int sel_of(int i);
        case (i)
            0:       return int'(sel_a);
            1:       return int'(sel_b);
            default: return int'(sel_c);
        endcase
    endfunction

    task automatic push_exp();
        for (int i = 0; i < 3; i++) begin
            exp_t e;
            int   s;
            s      = sel_of(i);
            e.inst = i;
            if (s == 0) begin
                e.q = d & wm[i]; e.qv = dv;
            end else if (s <= dep[i]) begin
                e.q = m_st[i][s]; e.qv = m_vl[i][s];
            end else begin
                e.q = '0; e.qv = 1'b0;
            end
            e.fill = m_fill[i];
            e.full = (m_fill[i] == dep[i]);
            sbq.push_back(e);
        end
    endtask

    task automatic get_dut(int i, output logic [7:0] q, output logic qv, output int f, output logic fu);
        case (i)
            0:       begin q = ifa.q;         qv = ifa.q_valid; f = int'(ifa.fill); fu = ifa.full; end
            1:       begin q = ifb.q;         qv = ifb.q_valid; f = int'(ifb.fill); fu = ifb.full; end
            default: begin q = {7'b0, ifc.q}; qv = ifc.q_valid; f = int'(ifc.fill); fu = ifc.full; end
        endcase
    endtask

    task automatic check_sb(string tag);
        while (sbq.size() > 0) begin
            exp_t       e;
            logic [7:0] q;
            logic       qv, fu;
            int         f;
            e = sbq.pop_front();
            get_dut(e.inst, q, qv, f, fu);
            chk($sformatf("%s_q_i%0d", tag, e.inst),    int'(q),  int'(e.q));
            chk($sformatf("%s_qv_i%0d", tag, e.inst),   int'(qv), int'(e.qv));
            chk($sformatf("%s_fill_i%0d", tag, e.inst), f,        e.fill);
            chk($sformatf("%s_full_i%0d", tag, e.inst), int'(fu), int'(e.full));
        end
    endtask

    task automatic step(string tag);
        model_edge();
        push_exp();
        @(posedge clk);
        #1;
        check_sb(tag);
    endtask

    task automatic load3(logic [7:0] a, logic [7:0] b, logic [7:0] c);
        en = 1'b1; dv = 1'b1;
        d = a; step("load");
        d = b; step("load");
        d = c; step("load");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b0; en = 1'b0; flush = 1'b0; dv = 1'b0; d = '0;
        sel_a = 2'd3; sel_b = 3'd5; sel_c = 1'b1;
        #2;
        model_clear();
        push_exp();
        check_sb("reset");
        @(negedge clk);
        reset = 1'b1;

        // Asynchronous reset mid-stream, observed without any clock edge.
        load3(8'hA5, 8'hA5, 8'hA5);
        #2;
        reset = 1'b0;
        model_clear();
        for (int s = 1; s <= 3; s++) begin
            sel_a = 2'(s);
            #1;
            chk("arst_q",  int'(ifa.q),       0);
            chk("arst_qv", int'(ifa.q_valid), 0);
        end
        chk("arst_fill", int'(ifa.fill), 0);
        chk("arst_full", int'(ifa.full), 0);
        push_exp();
        check_sb("arst");
        reset = 1'b1;

        // Flush has priority over a simultaneous enable; the presented word is lost.
        load3(8'h33, 8'h44, 8'h55);
        flush = 1'b1; en = 1'b1; d = 8'h11; dv = 1'b1;
        step("flush");
        flush = 1'b0;
        for (int s = 1; s <= 3; s++) begin
            sel_a = 2'(s);
            #1;
            chk("flush_q", int'(ifa.q), 0);
        end
        chk("flush_fill", int'(ifa.fill), 0);

        tv[0] = '{8'h01, 1'b1, 1'b1, 24'h000001, 3'b001, 1, 1'b0};
        tv[1] = '{8'h02, 1'b1, 1'b1, 24'h000102, 3'b011, 2, 1'b0};
        tv[2] = '{8'h03, 1'b1, 1'b1, 24'h010203, 3'b111, 3, 1'b1};
        tv[3] = '{8'h04, 1'b1, 1'b1, 24'h020304, 3'b111, 3, 1'b1};
        tv[4]  = '{8'h21, 1'b1, 1'b0, 24'h0, 3'b0, 1, 1'b0};
        tv[5]  = '{8'h22, 1'b0, 1'b0, 24'h0, 3'b0, 1, 1'b0};
        tv[6]  = '{8'h23, 1'b1, 1'b0, 24'h0, 3'b0, 2, 1'b0};
        tv[7]  = '{8'h24, 1'b1, 1'b0, 24'h0, 3'b0, 2, 1'b0};
        tv[8]  = '{8'h25, 1'b0, 1'b0, 24'h0, 3'b0, 2, 1'b0};
        tv[9]  = '{8'h26, 1'b0, 1'b0, 24'h0, 3'b0, 1, 1'b0};
        tv[10] = '{8'h27, 1'b0, 1'b0, 24'h0, 3'b0, 0, 1'b0};
        tv[11] = '{8'h28, 1'b1, 1'b0, 24'h0, 3'b0, 1, 1'b0};
        tv[12] = '{8'h29, 1'b1, 1'b0, 24'h0, 3'b0, 2, 1'b0};
        tv[13] = '{8'h2A, 1'b1, 1'b0, 24'h0, 3'b0, 3, 1'b1};
        tv[14] = '{8'h2B, 1'b1, 1'b0, 24'h0, 3'b0, 3, 1'b1};

        // Rows 0-3: tap delay; rows 4-14: occupancy pattern from empty.
        en = 1'b1;
        for (int i = 0; i < 15; i++) begin
            if (i == 4) begin
                flush = 1'b1;
                step("flush2");
                flush = 1'b0;
            end
            d = tv[i].d; dv = tv[i].dv;
            step("vec");
            if (tv[i].has_q) begin
                for (int s = 1; s <= 3; s++) begin
                    sel_a = 2'(s);
                    #1;
                    chk($sformatf("vec%0d_q_sel%0d", i, s),  int'(ifa.q),       int'(tv[i].q[8*s-1 -: 8]));
                    chk($sformatf("vec%0d_qv_sel%0d", i, s), int'(ifa.q_valid), int'(tv[i].v[s-1]));
                end
            end
            chk($sformatf("vec%0d_fill", i), int'(ifa.fill), tv[i].fill);
            chk($sformatf("vec%0d_full", i), int'(ifa.full), int'(tv[i].full));
        end

        // Bypass is combinational from d.
        sel_a = 2'd0; d = 8'h5A; dv = 1'b1;
        #1;
        chk("bypass_q",  int'(ifa.q),       8'h5A);
        chk("bypass_qv", int'(ifa.q_valid), 1);

        // Out-of-range taps on the five-stage instance, which holds valid data now.
        for (int s = 6; s <= 7; s++) begin
            sel_b = 3'(s);
            #1;
            chk($sformatf("oor_q_sel%0d", s),  int'(ifb.q),       0);
            chk($sformatf("oor_qv_sel%0d", s), int'(ifb.q_valid), 0);
        end

        // Stall: held state while en is low.
        flush = 1'b1; step("flush3"); flush = 1'b0;
        sel_a = 2'd3;
        load3(8'h10, 8'h20, 8'h30);
        en = 1'b0; d = 8'hFF;
        for (int c = 0; c < 5; c++) begin
            step("stall");
            chk("stall_q3",   int'(ifa.q),    8'h10);
            chk("stall_fill", int'(ifa.fill), 3);
            chk("stall_full", int'(ifa.full), 1);
        end
        en = 1'b1; d = 8'h40;
        step("resume");
        chk("resume_q3", int'(ifa.q), 8'h20);

        // Five-edge delay to the last tap of the deep instance.
        flush = 1'b1; step("flush4"); flush = 1'b0;
        sel_b = 3'd5; en = 1'b1; dv = 1'b1; d = 8'hC0;
        step("deep");
        dv = 1'b0; d = 8'h00;
        for (int e = 2; e <= 5; e++) begin
            chk($sformatf("deep_q5_e%0d", e - 1), int'(ifb.q), 0);
            step("deep");
        end
        chk("deep_q5",  int'(ifb.q),       8'hC0);
        chk("deep_qv5", int'(ifb.q_valid), 1);

        for (int n = 0; n < 400; n++) begin
            en    = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 19) == 0);
            dv    = 1'($urandom_range(0, 1));
            d     = 8'($urandom);
            sel_a = 2'($urandom);
            sel_b = 3'($urandom);
            sel_c = 1'($urandom);
            step("rand");
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
